// File: rtl/friscv_pkg.sv
// Shared FRISCV definitions: datapath width, RV32M funct3 codes and the
// mul/div sequencer states.
package friscv_pkg;

  localparam int XLEN = 32;

  typedef enum logic [2:0] {
    MUL    = 3'b000,
    MULH   = 3'b001,
    MULHSU = 3'b010,
    MULHU  = 3'b011,
    DIV    = 3'b100,
    DIVU   = 3'b101,
    REM    = 3'b110,
    REMU   = 3'b111
  } MULDIV_OPS;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } muldiv_state_t;

endpackage

// File: rtl/friscv_muldiv.sv
// Iterative RV32M multiply/divide unit: one shift-add or restoring-subtract
// step per cycle on a single shared accumulator, signs fixed up on completion.
module friscv_muldiv
  import friscv_pkg::*;
#(
  parameter int XLEN = friscv_pkg::XLEN
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start_i,
  input  logic [2:0]      op_i,
  input  logic [XLEN-1:0] a_i,
  input  logic [XLEN-1:0] b_i,
  input  logic            flush_i,
  output logic            busy_o,
  output logic            valid_o,
  output logic [XLEN-1:0] result_o
);

  localparam int CW = $clog2(XLEN + 1);
  localparam int AW = 2 * XLEN + 1;
  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  muldiv_state_t   state_q, state_d;
  MULDIV_OPS       op_q, op_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [AW-1:0]   acc_q, acc_d;
  logic [XLEN-1:0] opnd_q, opnd_d;
  logic            neg_lo_q, neg_lo_d;
  logic            neg_hi_q, neg_hi_d;
  logic            valid_q, valid_d;
  logic [XLEN-1:0] result_q, result_d;

  logic            is_div, a_signed, b_signed, sign_a, sign_b;
  logic            div_zero, div_ovf;
  logic [XLEN-1:0] mag_a, mag_b, special_res;

  // Operand decode: magnitudes plus the RV32M-defined divide corner results.
  always_comb begin
    is_div   = op_i[2];
    a_signed = is_div ? !op_i[0] : (op_i[1:0] != 2'b11);
    b_signed = is_div ? !op_i[0] : !op_i[1];
    sign_a   = a_signed & a_i[XLEN-1];
    sign_b   = b_signed & b_i[XLEN-1];
    mag_a    = sign_a ? -a_i : a_i;
    mag_b    = sign_b ? -b_i : b_i;
    div_zero = is_div && (b_i == '0);
    div_ovf  = is_div && !op_i[0] && (a_i == MIN_NEG) && (b_i == '1);
    if (div_zero) begin
      special_res = op_i[1] ? a_i : '1;
    end else begin
      special_res = op_i[1] ? '0 : a_i;
    end
  end

  logic [XLEN:0]     mul_sum, rem_shift, rem_diff;
  logic [AW-1:0]     step;
  logic [2*XLEN-1:0] prod_fix;
  logic [XLEN-1:0]   quot_fix, rem_fix, final_res;

  // Divide keeps {remainder, dividend/quotient}; multiply keeps {partial, multiplier}.
  always_comb begin
    mul_sum   = acc_q[AW-1:XLEN] + (acc_q[0] ? {1'b0, opnd_q} : '0);
    rem_shift = acc_q[2*XLEN-1:XLEN-1];
    rem_diff  = rem_shift - {1'b0, opnd_q};
    if (op_q[2]) begin
      if (rem_shift >= {1'b0, opnd_q}) begin
        step = {rem_diff, acc_q[XLEN-2:0], 1'b1};
      end else begin
        step = {rem_shift, acc_q[XLEN-2:0], 1'b0};
      end
    end else begin
      step = {1'b0, mul_sum, acc_q[XLEN-1:1]};
    end

    prod_fix = neg_lo_q ? -step[2*XLEN-1:0] : step[2*XLEN-1:0];
    quot_fix = neg_lo_q ? -step[XLEN-1:0] : step[XLEN-1:0];
    rem_fix  = neg_hi_q ? -step[2*XLEN-1:XLEN] : step[2*XLEN-1:XLEN];

    case (op_q)
      MUL:                 final_res = prod_fix[XLEN-1:0];
      MULH, MULHSU, MULHU: final_res = prod_fix[2*XLEN-1:XLEN];
      DIV, DIVU:           final_res = quot_fix;
      default:             final_res = rem_fix;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    opnd_d   = opnd_q;
    neg_lo_d = neg_lo_q;
    neg_hi_d = neg_hi_q;
    valid_d  = 1'b0;
    result_d = result_q;

    case (state_q)
      IDLE: begin
        if (start_i) begin
          op_d     = MULDIV_OPS'(op_i);
          neg_lo_d = sign_a ^ sign_b;
          neg_hi_d = sign_a;
          cnt_d    = '0;
          if (div_zero || div_ovf) begin
            acc_d   = {{(XLEN+1){1'b0}}, special_res};
            state_d = DONE;
          end else begin
            acc_d   = {{(XLEN+1){1'b0}}, is_div ? mag_a : mag_b};
            opnd_d  = is_div ? mag_b : mag_a;
            state_d = CALC;
          end
        end
      end
      CALC: begin
        acc_d = step;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CW'(XLEN - 1)) begin
          acc_d   = {{(XLEN+1){1'b0}}, final_res};
          cnt_d   = '0;
          state_d = DONE;
        end
      end
      DONE: begin
        state_d  = IDLE;
        valid_d  = 1'b1;
        result_d = acc_q[XLEN-1:0];
      end
      default: state_d = IDLE;
    endcase

    // Abandoning an operation must not disturb the last published result.
    if (flush_i) begin
      state_d  = IDLE;
      cnt_d    = '0;
      valid_d  = 1'b0;
      result_d = result_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      op_q     <= MUL;
      cnt_q    <= '0;
      acc_q    <= '0;
      opnd_q   <= '0;
      neg_lo_q <= 1'b0;
      neg_hi_q <= 1'b0;
      valid_q  <= 1'b0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      opnd_q   <= opnd_d;
      neg_lo_q <= neg_lo_d;
      neg_hi_q <= neg_hi_d;
      valid_q  <= valid_d;
      result_q <= result_d;
    end
  end

  assign busy_o   = (state_q != IDLE);
  assign valid_o  = valid_q;
  assign result_o = result_q;

endmodule

// File: tb/tb_friscv_muldiv.sv
// Self-checking bench for friscv_muldiv: directed RV32M vectors, randomized
// operations against an arithmetic reference, flush/reset aborts and back-to-back issue.
module tb_friscv_muldiv;
  import friscv_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start_i = 1'b0;
  logic        flush_i = 1'b0;
  logic [2:0]  op_i = 3'b000;
  logic [31:0] a_i = '0;
  logic [31:0] b_i = '0;
  logic        busy_o;
  logic        valid_o;
  logic [31:0] result_o;

  int checks = 0;
  int failures = 0;

  friscv_muldiv #(.XLEN(32)) dut (
    .clk      (clk),
    .rst      (rst),
    .start_i  (start_i),
    .op_i     (op_i),
    .a_i      (a_i),
    .b_i      (b_i),
    .flush_i  (flush_i),
    .busy_o   (busy_o),
    .valid_o  (valid_o),
    .result_o (result_o)
  );

  always #5 clk = ~clk;

  // Reference results straight from the RV32M arithmetic definitions.
  function automatic logic [31:0] model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    longint      sa, sb;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (op)
      MUL:    begin p = 64'(sa * sb); return p[31:0]; end
      MULH:   begin p = 64'(sa * sb); return p[63:32]; end
      MULHSU: begin p = 64'(sa * longint'({32'd0, b})); return p[63:32]; end
      MULHU:  begin p = {32'd0, a} * {32'd0, b}; return p[63:32]; end
      DIV: begin
        if (b == 32'd0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a;
        return 32'(sa / sb);
      end
      DIVU: return (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
      REM: begin
        if (b == 32'd0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
        return 32'(sa % sb);
      end
      default: return (b == 32'd0) ? a : a % b;
    endcase
  endfunction

  function automatic int model_latency(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    bit is_divide, overflow;
    is_divide = (op == DIV) || (op == DIVU) || (op == REM) || (op == REMU);
    overflow  = ((op == DIV) || (op == REM)) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF;
    return (is_divide && (b == 32'd0 || overflow)) ? 1 : 33;
  endfunction

  // Issues one operation, scrambles the inputs after acceptance, and measures
  // latency (cycles after the accepting edge) and busy cycles.
  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] res, output int lat, output int busy_n,
                        output bit tail_bad);
    @(negedge clk);
    start_i = 1'b1; op_i = op; a_i = a; b_i = b;
    @(negedge clk);
    start_i = 1'b0; op_i = 3'($urandom_range(0, 7)); a_i = $urandom; b_i = $urandom;
    lat = -1; busy_n = 0; res = 'x;
    for (int n = 0; n < 80; n++) begin
      if (n > 0) @(negedge clk);
      if (busy_o) busy_n++;
      if (valid_o) begin
        lat = n;
        res = result_o;
        break;
      end
    end
    @(negedge clk);
    tail_bad = valid_o || busy_o;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1; start_i = 1'b1; op_i = MUL; a_i = 32'd3; b_i = 32'd4;
    @(negedge clk);
    @(negedge clk);
    checks++; if (busy_o !== 1'b0) begin failures++; $display("[TB] FAIL reset busy: got %b, expected 0", busy_o); end
    checks++; if (valid_o !== 1'b0) begin failures++; $display("[TB] FAIL reset valid: got %b, expected 0", valid_o); end
    checks++; if (result_o !== 32'd0) begin failures++; $display("[TB] FAIL reset result: got %h, expected 0", result_o); end
    rst = 1'b0; start_i = 1'b0;
    @(negedge clk);
    checks++; if (busy_o !== 1'b0) begin failures++; $display("[TB] FAIL start-during-reset busy: got %b, expected 0", busy_o); end
  endtask

  task automatic test_directed();
    logic [2:0]  d_op [12] = '{MUL, MULH, MULHU, MULHSU, DIV, REM, DIVU, REMU, DIVU, REM, DIV, REM};
    logic [31:0] d_a  [12] = '{32'd7, 32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFF9, 32'hFFFF_FFF9,
                               32'd100, 32'd100, 32'd5, 32'd5, 32'h8000_0000, 32'h8000_0000};
    logic [31:0] d_b  [12] = '{32'hFFFF_FFFD, 32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd2, 32'd2,
                               32'd7, 32'd7, 32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    logic [31:0] d_exp[12] = '{32'hFFFF_FFEB, 32'h4000_0000, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 32'hFFFF_FFFF,
                               32'd14, 32'd2, 32'hFFFF_FFFF, 32'd5, 32'h8000_0000, 32'd0};
    int          d_lat[12] = '{33, 33, 33, 33, 33, 33, 33, 33, 1, 1, 1, 1};
    logic [31:0] res;
    int          lat, busy_n;
    bit          tail_bad;
    for (int i = 0; i < 12; i++) begin
      run_op(d_op[i], d_a[i], d_b[i], res, lat, busy_n, tail_bad);
      checks++; if (res !== d_exp[i]) begin failures++; $display("[TB] FAIL directed[%0d] result: got %h, expected %h", i, res, d_exp[i]); end
      checks++; if (lat != d_lat[i]) begin failures++; $display("[TB] FAIL directed[%0d] latency: got %0d, expected %0d", i, lat, d_lat[i]); end
      checks++; if (busy_n != d_lat[i]) begin failures++; $display("[TB] FAIL directed[%0d] busy cycles: got %0d, expected %0d", i, busy_n, d_lat[i]); end
      checks++; if (tail_bad) begin failures++; $display("[TB] FAIL directed[%0d] strobe tail: got busy/valid high, expected both low", i); end
    end
  endtask

  task automatic test_random();
    logic [2:0]  op;
    logic [31:0] a, b, res, exp_res;
    int          lat, busy_n, exp_lat;
    bit          tail_bad;
    for (int i = 0; i < 40; i++) begin
      op = 3'($urandom_range(0, 7));
      a  = $urandom;
      b  = $urandom;
      case ($urandom_range(0, 9))
        0: b = 32'd0;
        1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
        2: b = $urandom_range(1, 15);
        3: a = $urandom_range(0, 1000);
        default: ;
      endcase
      exp_res = model(op, a, b);
      exp_lat = model_latency(op, a, b);
      run_op(op, a, b, res, lat, busy_n, tail_bad);
      checks++; if (res !== exp_res) begin failures++; $display("[TB] FAIL random[%0d] op=%0d a=%h b=%h result: got %h, expected %h", i, op, a, b, res, exp_res); end
      checks++; if (lat != exp_lat) begin failures++; $display("[TB] FAIL random[%0d] latency: got %0d, expected %0d", i, lat, exp_lat); end
    end
  endtask

  task automatic test_flush();
    logic [31:0] res;
    int          lat, busy_n;
    bit          tail_bad, bad;
    run_op(DIVU, 32'd100, 32'd7, res, lat, busy_n, tail_bad);
    checks++; if (res !== 32'd14) begin failures++; $display("[TB] FAIL flush setup result: got %h, expected 0000000e", res); end
    @(negedge clk);
    start_i = 1'b1; op_i = MUL; a_i = 32'h1234_5678; b_i = 32'h9ABC_DEF0;
    @(negedge clk);
    start_i = 1'b0;
    repeat (10) @(negedge clk);
    flush_i = 1'b1;
    @(negedge clk);
    flush_i = 1'b0;
    checks++; if (busy_o !== 1'b0) begin failures++; $display("[TB] FAIL flush busy: got %b, expected 0", busy_o); end
    checks++; if (valid_o !== 1'b0) begin failures++; $display("[TB] FAIL flush valid: got %b, expected 0", valid_o); end
    checks++; if (result_o !== 32'd14) begin failures++; $display("[TB] FAIL flush result: got %h, expected 0000000e", result_o); end
    bad = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (valid_o || result_o !== 32'd14) bad = 1'b1;
    end
    checks++; if (bad) begin failures++; $display("[TB] FAIL flush aftermath: got stray valid or changed result, expected none"); end
    @(negedge clk);
    start_i = 1'b1; flush_i = 1'b1; op_i = MUL; a_i = 32'd2; b_i = 32'd3;
    @(negedge clk);
    start_i = 1'b0; flush_i = 1'b0;
    checks++; if (busy_o !== 1'b0) begin failures++; $display("[TB] FAIL flush-over-start busy: got %b, expected 0", busy_o); end
    run_op(MUL, 32'd7, 32'hFFFF_FFFD, res, lat, busy_n, tail_bad);
    checks++; if (res !== 32'hFFFF_FFEB) begin failures++; $display("[TB] FAIL post-flush result: got %h, expected ffffffeb", res); end
  endtask

  task automatic test_reset_mid();
    bit bad;
    @(negedge clk);
    start_i = 1'b1; op_i = MULHU; a_i = $urandom; b_i = $urandom;
    @(negedge clk);
    start_i = 1'b0;
    repeat (20) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++; if (busy_o !== 1'b0) begin failures++; $display("[TB] FAIL mid-reset busy: got %b, expected 0", busy_o); end
    checks++; if (valid_o !== 1'b0) begin failures++; $display("[TB] FAIL mid-reset valid: got %b, expected 0", valid_o); end
    checks++; if (result_o !== 32'd0) begin failures++; $display("[TB] FAIL mid-reset result: got %h, expected 0", result_o); end
    bad = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (valid_o || busy_o) bad = 1'b1;
    end
    checks++; if (bad) begin failures++; $display("[TB] FAIL mid-reset aftermath: got activity, expected idle"); end
  endtask

  task automatic test_back_to_back();
    logic [2:0]  q_op [5] = '{MUL, DIVU, REM, MULH, DIV};
    logic [31:0] q_a  [5];
    logic [31:0] q_b  [5];
    int          exp_cycle [5];
    int          k;
    bit          prev_valid, adjacent;
    q_a[0] = $urandom; q_b[0] = $urandom;
    q_a[1] = $urandom; q_b[1] = 32'd0;
    q_a[2] = $urandom; q_b[2] = $urandom_range(1, 1000);
    q_a[3] = $urandom; q_b[3] = $urandom;
    q_a[4] = 32'h8000_0000; q_b[4] = 32'hFFFF_FFFF;
    exp_cycle[0] = model_latency(q_op[0], q_a[0], q_b[0]);
    for (int i = 1; i < 5; i++) exp_cycle[i] = exp_cycle[i-1] + 1 + model_latency(q_op[i], q_a[i], q_b[i]);
    @(negedge clk);
    start_i = 1'b1; op_i = q_op[0]; a_i = q_a[0]; b_i = q_b[0];
    k = 0; prev_valid = 1'b0; adjacent = 1'b0;
    for (int c = 0; c < exp_cycle[4] + 40; c++) begin
      @(negedge clk);
      if (valid_o) begin
        if (prev_valid) adjacent = 1'b1;
        if (k < 5) begin
          checks++; if (result_o !== model(q_op[k], q_a[k], q_b[k])) begin failures++; $display("[TB] FAIL b2b[%0d] result: got %h, expected %h", k, result_o, model(q_op[k], q_a[k], q_b[k])); end
          checks++; if (c != exp_cycle[k]) begin failures++; $display("[TB] FAIL b2b[%0d] strobe cycle: got %0d, expected %0d", k, c, exp_cycle[k]); end
        end
        k++;
        if (k < 5) begin
          op_i = q_op[k]; a_i = q_a[k]; b_i = q_b[k];
        end else begin
          start_i = 1'b0;
        end
      end
      prev_valid = valid_o;
    end
    start_i = 1'b0;
    checks++; if (k != 5) begin failures++; $display("[TB] FAIL b2b strobe count: got %0d, expected 5", k); end
    checks++; if (adjacent) begin failures++; $display("[TB] FAIL b2b adjacency: got strobes in adjacent cycles, expected separated"); end
  endtask

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got no completion, expected end of test");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_flush();
    test_reset_mid();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
